// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI register controller:
//                FSM state encoding, command read-bit position and register
//                address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int CMD_RD_BIT = 7;
  localparam int REG_ADDR_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WR_REQ = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_DATA   = 3'd4
  } state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_ctrl
//  Description : Turns a stream of SPI bytes into register-bus accesses.
//                The first byte of a transfer is a command (bit7 = read,
//                bits[6:0] = start address); following bytes are write data
//                or read-prefetch triggers.
//  Ports       : clk, rst              - clock, async active-high reset
//                xfer_active           - chip-select asserted
//                byte_stb, rx_byte     - received byte strobe and value
//                tx_byte               - next byte to shift out
//                reg_addr/wdata/we/re  - register bus request
//                reg_rdata, reg_ack    - register bus completion
//                overrun               - sticky byte-dropped flag
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter bit         AUTO_INC  = 1'b1,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  xfer_active,
  input  logic                  byte_stb,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            tx_byte,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  input  logic                  reg_ack,
  output logic                  overrun
);

  localparam logic [REG_ADDR_W-1:0] c_addr_one = 1;

  state_t r_state;
  state_t w_next_state;
  logic   r_xfer_d;
  logic   r_is_read;
  logic   r_ended;
  logic   w_xfer_rise;
  logic   w_done;

  // r_xfer_d resets high so a transfer already active at reset release is
  // not seen as a rising edge; it must drop and rise again.
  assign w_xfer_rise = xfer_active & ~r_xfer_d;
  // Remembers a chip-select drop during a bus access so that a quick
  // re-assertion cannot resume the old transfer.
  assign w_done      = ~xfer_active | r_ended;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer_rise) w_next_state = ST_CMD;
      end
      ST_CMD: begin
        if (!xfer_active)  w_next_state = ST_IDLE;
        else if (byte_stb) w_next_state = rx_byte[CMD_RD_BIT] ? ST_RD_REQ : ST_DATA;
      end
      ST_DATA: begin
        if (!xfer_active)  w_next_state = ST_IDLE;
        else if (byte_stb) w_next_state = r_is_read ? ST_RD_REQ : ST_WR_REQ;
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (reg_ack) w_next_state = w_done ? ST_IDLE : ST_DATA;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: requests are a pure function of state, so they drop
  // immediately on reset and can never be high together.
  always_comb begin
    reg_we = 1'b0;
    reg_re = 1'b0;
    case (r_state)
      ST_WR_REQ: reg_we = 1'b1;
      ST_RD_REQ: reg_re = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xfer_d  <= 1'b1;
      r_is_read <= 1'b0;
      r_ended   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_byte   <= FILL_BYTE;
      overrun   <= 1'b0;
    end else begin
      r_xfer_d <= xfer_active;
      case (r_state)
        ST_IDLE: begin
          tx_byte   <= FILL_BYTE;
          r_is_read <= 1'b0;
          r_ended   <= 1'b0;
          if (w_xfer_rise) overrun <= 1'b0;
        end
        ST_CMD: begin
          if (xfer_active && byte_stb) begin
            reg_addr  <= rx_byte[REG_ADDR_W-1:0];
            r_is_read <= rx_byte[CMD_RD_BIT];
          end
        end
        ST_DATA: begin
          if (xfer_active && byte_stb) begin
            // Read transfers ignore the received byte; the shift-out value
            // reverts to fill until the prefetch completes.
            if (r_is_read) tx_byte   <= FILL_BYTE;
            else           reg_wdata <= rx_byte;
          end
        end
        ST_WR_REQ, ST_RD_REQ: begin
          if (!xfer_active) r_ended <= 1'b1;
          if (byte_stb)     overrun <= 1'b1;
          if (reg_ack) begin
            if (AUTO_INC)              reg_addr <= reg_addr + c_addr_one;
            if (r_state == ST_RD_REQ)  tx_byte  <= reg_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : spi_reg_ctrl
`default_nettype wire
